// File: rtl/chaos_tx_ctl.sv
// Chaosnet transmit sequencer: loads host words into the 256x16 transmit buffer,
// then streams the frame MSB-first with a trailing CRC-16-CCITT.
module chaos_tx_ctl #(
  parameter int BIT_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] host_data,
  input  logic        host_wr,
  input  logic        host_clr,
  input  logic        host_go,
  output logic [15:0] datain,
  output logic [7:0]  tbct,
  output logic        twp,
  output logic        trp,
  input  logic [15:0] tdata,
  output logic        tx_en,
  output logic        tx_bit,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [8:0]  wcount
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, CRC} state_t;

  state_t      r_state;
  logic [15:0] r_datain;
  logic [7:0]  r_tbct;
  logic        r_twp;
  logic        r_trp;
  logic        r_tx_en;
  logic        r_tx_bit;
  logic        r_busy;
  logic        r_done;
  logic        r_ovf;
  logic [8:0]  r_wcount;
  logic [7:0]  r_rptr;
  logic [15:0] r_crc;
  logic [15:0] r_shreg;
  logic [3:0]  r_bitcnt;
  logic [7:0]  r_divcnt;

  logic [15:0] w_crc_nxt;
  logic        w_more;
  logic        w_bit_end;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ (((c[15] ^ b) == 1'b1) ? 16'h1021 : 16'h0000);
  endfunction

  assign w_crc_nxt = crc_step(r_crc, r_shreg[15]);
  assign w_more    = ({1'b0, r_rptr} + 9'd1) < r_wcount;
  assign w_bit_end = (r_divcnt == 8'(BIT_DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_datain <= '0;
      r_tbct   <= '0;
      r_twp    <= 1'b0;
      r_trp    <= 1'b0;
      r_tx_en  <= 1'b0;
      r_tx_bit <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_wcount <= '0;
      r_rptr   <= '0;
      r_crc    <= '0;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_divcnt <= '0;
    end else begin
      r_twp <= 1'b0;
      r_trp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (host_clr) begin
            r_wcount <= '0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
          end else if (host_wr) begin
            if (r_wcount[8]) begin
              r_ovf <= 1'b1;
            end else begin
              r_twp    <= 1'b1;
              r_tbct   <= r_wcount[7:0];
              r_datain <= host_data;
              r_wcount <= r_wcount + 9'd1;
            end
          end else if (host_go && (r_wcount != 9'd0)) begin
            r_done  <= 1'b0;
            r_rptr  <= '0;
            r_crc   <= 16'hFFFF;
            r_trp   <= 1'b1;
            r_tbct  <= '0;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: r_state <= WAIT;
        WAIT: begin
          r_shreg  <= tdata;
          r_tx_en  <= 1'b1;
          r_tx_bit <= tdata[15];
          r_bitcnt <= '0;
          r_divcnt <= '0;
          r_state  <= SHIFT;
        end
        SHIFT, CRC: begin
          if (!w_bit_end) begin
            r_divcnt <= r_divcnt + 8'd1;
          end else begin
            r_divcnt <= '0;
            if (r_state == SHIFT) r_crc <= w_crc_nxt;
            if (r_bitcnt != 4'd15) begin
              r_shreg  <= {r_shreg[14:0], 1'b0};
              r_tx_bit <= r_shreg[14];
              r_bitcnt <= r_bitcnt + 4'd1;
              // Prefetch the next word during bit 15 so words abut without gaps
              if (r_state == SHIFT && r_bitcnt == 4'd14 && w_more) begin
                r_trp  <= 1'b1;
                r_tbct <= r_rptr + 8'd1;
              end
            end else if (r_state == SHIFT && w_more) begin
              r_shreg  <= tdata;
              r_tx_bit <= tdata[15];
              r_rptr   <= r_rptr + 8'd1;
              r_bitcnt <= '0;
            end else if (r_state == SHIFT) begin
              r_shreg  <= w_crc_nxt;
              r_tx_bit <= w_crc_nxt[15];
              r_bitcnt <= '0;
              r_state  <= CRC;
            end else begin
              r_tx_en  <= 1'b0;
              r_tx_bit <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign datain   = r_datain;
  assign tbct     = r_tbct;
  assign twp      = r_twp;
  assign trp      = r_trp;
  assign tx_en    = r_tx_en;
  assign tx_bit   = r_tx_bit;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_ovf;
  assign wcount   = r_wcount;

endmodule

// File: tb/tb_chaos_tx_ctl.sv
// Randomized bench for chaos_tx_ctl: a frame-timeline reference model predicts
// every output each cycle; literal checks pin the model on known frames.
module tb_chaos_tx_ctl;
  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] host_data = '0;
  logic        host_wr = 1'b0, host_clr = 1'b0, host_go = 1'b0;
  logic [15:0] datain;
  logic [7:0]  tbct;
  logic        twp, trp;
  logic [15:0] tdata = '0;
  logic        tx_en, tx_bit, busy, done, overflow;
  logic [8:0]  wcount;

  chaos_tx_ctl #(.BIT_DIV(BD)) dut (
    .clk(clk), .reset(reset), .host_data(host_data), .host_wr(host_wr),
    .host_clr(host_clr), .host_go(host_go), .datain(datain), .tbct(tbct),
    .twp(twp), .trp(trp), .tdata(tdata), .tx_en(tx_en), .tx_bit(tx_bit),
    .busy(busy), .done(done), .overflow(overflow), .wcount(wcount));

  always #5 clk = ~clk;

  // Transmit buffer: write at the edge ending a twp cycle, read data valid after trp
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (twp) mem[tbct] <= datain;
    if (trp) tdata <= mem[tbct];
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_mem [256];
  int          m_cnt, m_t, m_nb, m_nw;
  bit          m_ovf, m_done, m_busy;
  bit          stream [0:4111];
  bit          e_twp, e_trp, e_txen, e_txbit;
  logic [7:0]  e_tbct;
  logic [15:0] e_datain;

  task automatic build_stream();
    logic [15:0] c;
    int k;
    bit b, fb;
    c = 16'hFFFF;
    k = 0;
    for (int w = 0; w < m_cnt; w++) begin
      for (int i = 15; i >= 0; i--) begin
        b = m_mem[w][i];
        stream[k] = b;
        k++;
        fb = c[15] ^ b;
        c = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    for (int i = 15; i >= 0; i--) begin
      stream[k] = c[i];
      k++;
    end
    m_nw = m_cnt;
    m_nb = k;
  endtask

  task automatic model_step();
    int p;
    if (!reset) begin
      m_cnt = 0; m_t = 0; m_ovf = 0; m_done = 0; m_busy = 0;
      e_twp = 0; e_trp = 0; e_txen = 0; e_txbit = 0; e_tbct = 0; e_datain = 0;
      return;
    end
    e_twp = 0;
    e_trp = 0;
    if (m_busy) begin
      m_t++;
      p = m_t - 3;
      e_txen = 0;
      e_txbit = 0;
      if (p >= 0 && p < m_nb * BD) begin
        e_txen = 1;
        e_txbit = stream[p / BD];
        if (p % (16 * BD) == 15 * BD && p / (16 * BD) < m_nw - 1) begin
          e_trp = 1;
          e_tbct = 8'(p / (16 * BD) + 1);
        end
      end else if (p == m_nb * BD) begin
        m_busy = 0;
        m_done = 1;
      end
    end else if (host_clr) begin
      m_cnt = 0; m_done = 0; m_ovf = 0;
    end else if (host_wr) begin
      if (m_cnt == 256) m_ovf = 1;
      else begin
        e_twp = 1;
        e_tbct = 8'(m_cnt);
        e_datain = host_data;
        m_mem[m_cnt] = host_data;
        m_cnt++;
      end
    end else if (host_go && m_cnt != 0) begin
      build_stream();
      m_busy = 1; m_t = 1; m_done = 0;
      e_trp = 1; e_tbct = 0;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  // ---------------- per-cycle compare + monitors ----------------
  bit cmp_en = 0;
  bit txq [$];
  int twp_cnt = 0, pref_cnt = 0;
  logic [7:0] pref_tbct = 0;

  initial forever begin
    @(negedge clk);
    if (tx_en) txq.push_back(tx_bit);
    if (twp) twp_cnt++;
    if (trp && tx_en) begin pref_cnt++; pref_tbct = tbct; end
    if (cmp_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("overflow", overflow, m_ovf);
      check("wcount", wcount, m_cnt);
      check("tx_en", tx_en, e_txen);
      check("tx_bit", tx_bit, e_txbit);
      check("twp", twp, e_twp);
      check("trp", trp, e_trp);
      if (e_twp || e_trp) check("tbct", tbct, e_tbct);
      if (e_twp) check("datain", datain, e_datain);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cmd(input bit wr, input bit clr, input bit go, input logic [15:0] d);
    host_wr = wr; host_clr = clr; host_go = go; host_data = d;
    @(negedge clk);
    host_wr = 0; host_clr = 0; host_go = 0;
  endtask

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    while (busy && n < 6000) begin
      if (noise) begin
        host_wr  = ($urandom_range(0, 7) == 0);
        host_clr = ($urandom_range(0, 15) == 0);
        host_go  = ($urandom_range(0, 7) == 0);
        host_data = 16'($urandom);
      end
      @(negedge clk);
      n++;
    end
    host_wr = 0; host_clr = 0; host_go = 0;
    check("idle_timeout", busy, 1'b0);
  endtask

  function automatic logic [15:0] bits16(input int base);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[15 - i] = txq[(base + i) * BD];
    return v;
  endfunction

  initial begin
    #12;
    check("rst_outs", {datain, tbct, twp, trp, tx_en, tx_bit, busy, done, overflow}, '0);
    check("rst_wcount", wcount, 9'd0);
    @(negedge clk);
    reset = 1'b1;
    cmp_en = 1;
    @(negedge clk);

    // Single zero word
    cmd(1, 0, 0, 16'h0000);
    txq.delete();
    cmd(0, 0, 1, 16'h0);
    check("go_busy", busy, 1'b1);
    check("go_trp", trp, 1'b1);
    wait_idle(0);
    check("zero_len", txq.size(), 128);
    if (txq.size() == 128) check("zero_bits", {bits16(0), bits16(16)}, 32'h00001D0F);
    check("zero_done", done, 1'b1);

    // Two words, prefetch placement
    cmd(0, 1, 0, 16'h0);
    check("clr_done", done, 1'b0);
    cmd(1, 0, 0, 16'hA5F0);
    cmd(1, 0, 0, 16'h0F0F);
    txq.delete(); pref_cnt = 0;
    cmd(0, 0, 1, 16'h0);
    wait_idle(0);
    check("two_len", txq.size(), 192);
    if (txq.size() == 192) begin
      check("two_w0", bits16(0), 16'hA5F0);
      check("two_w1", bits16(16), 16'h0F0F);
    end
    check("pref_cnt", pref_cnt, 1);
    check("pref_tbct", pref_tbct, 8'd1);
    cmd(0, 0, 1, 16'h0);
    wait_idle(0);

    // Randomized frames with commands injected while busy
    for (int it = 0; it < 8; it++) begin
      cmd(0, 1, 0, 16'h0);
      for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
        cmd(1, 0, 0, 16'($urandom));
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
      cmd(0, 0, 1, 16'h0);
      wait_idle(1);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Same-cycle command priority and empty go
    cmd(0, 1, 0, 16'h0);
    cmd(1, 0, 1, 16'h1234);
    check("wrgo_busy", busy, 1'b0);
    check("wrgo_twp", twp, 1'b1);
    check("wrgo_wcount", wcount, 9'd1);
    cmd(1, 1, 0, 16'h5678);
    check("clrwr_wcount", wcount, 9'd0);
    check("clrwr_twp", twp, 1'b0);
    cmd(0, 0, 1, 16'h0);
    check("emptygo_busy", busy, 1'b0);

    // Fill to overflow
    twp_cnt = 0;
    for (int i = 0; i < 257; i++) cmd(1, 0, 0, 16'(i * 3));
    @(negedge clk);
    check("fill_twp", twp_cnt, 256);
    check("fill_wcount", wcount, 9'd256);
    check("fill_ovf", overflow, 1'b1);
    cmd(0, 1, 0, 16'h0);
    check("fill_clr_wcount", wcount, 9'd0);
    check("fill_clr_ovf", overflow, 1'b0);

    // Reset mid-frame at word 1 bit 7
    cmd(1, 0, 0, 16'hBEEF);
    cmd(1, 0, 0, 16'hC0DE);
    cmd(0, 0, 1, 16'h0);
    repeat (2 + 16 * BD + 7 * BD + 1) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_txen", tx_en, 1'b0);
    check("abort_outs", {datain, tbct, twp, trp, tx_bit, busy, done, overflow}, '0);
    check("abort_wcount", wcount, 9'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cmd(1, 0, 0, 16'h0000);
    txq.delete();
    cmd(0, 0, 1, 16'h0);
    wait_idle(0);
    check("fresh_len", txq.size(), 128);
    if (txq.size() == 128) check("fresh_crc", bits16(16), 16'h1D0F);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
